// File: rtl/io_bridge_bip2_if.sv
`default_nettype none
// ============================================================================
// Module      : io_bridge_bip2_if
// Description : Processor data-memory port bundle (write strobe, address,
//               write data, read data) between the CPU and the I/O bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface io_bridge_bip2_if #(
    parameter int MSB_OPERAND = 11,
    parameter int MSB_ROM     = 11
);
    logic                   WRRAM_i;
    logic [MSB_ROM-1:0]     ADDR_dm_i;
    logic [MSB_OPERAND-1:0] IN_DATA_i;
    logic [MSB_OPERAND-1:0] OUT_DATA_o;

    // master = processor side, slave = bridge side
    modport master (output WRRAM_i, ADDR_dm_i, IN_DATA_i, input OUT_DATA_o);
    modport slave  (input WRRAM_i, ADDR_dm_i, IN_DATA_i, output OUT_DATA_o);
endinterface
`default_nettype wire

// File: rtl/io_bridge_bip2.sv
`default_nettype none
// ============================================================================
// Module      : io_bridge_bip2
// Description : Data-memory bridge: addresses below IO_BASE go to RAM, the
//               rest decode to GPIO, a prescaled timer and an 8N1 UART TX.
//               Optional macro TIMER_AUTORELOAD_EN: periodic timer reload.
// Revision    : 1.0 - initial release
// ============================================================================
module io_bridge_bip2 #(
    parameter int                 MSB_OPERAND = 11,
    parameter int                 MSB_ROM     = 11,
    parameter logic [MSB_ROM-1:0] IO_BASE     = 11'h400,
    parameter int                 PRESCALE    = 4,
    parameter int                 BAUD_DIV    = 16
) (
    input  wire logic                   CLOCK_i,
    input  wire logic                   RESET_i,
    io_bridge_bip2_if.slave             dm,
    output logic                        WRRAM_ram_o,
    output logic [MSB_ROM-1:0]          ADDR_ram_o,
    output logic [MSB_OPERAND-1:0]      DATA_ram_o,
    input  wire logic [MSB_OPERAND-1:0] DATA_ram_i,
    input  wire logic [7:0]             GPIO_i,
    output logic [7:0]                  GPIO_o,
    output logic                        UART_TX_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = $clog2(BAUD_DIV);

    localparam logic [MSB_ROM-1:0] c_OFF_GPIO_OUT  = MSB_ROM'(0);
    localparam logic [MSB_ROM-1:0] c_OFF_GPIO_IN   = MSB_ROM'(1);
    localparam logic [MSB_ROM-1:0] c_OFF_TIMER_CNT = MSB_ROM'(2);
    localparam logic [MSB_ROM-1:0] c_OFF_TIMER_CMP = MSB_ROM'(3);
    localparam logic [MSB_ROM-1:0] c_OFF_STATUS    = MSB_ROM'(4);
    localparam logic [MSB_ROM-1:0] c_OFF_UART_TX   = MSB_ROM'(5);
    localparam logic [PW-1:0]      c_PRESC_LAST    = PW'(PRESCALE - 1);
    localparam logic [BW-1:0]      c_BAUD_LAST     = BW'(BAUD_DIV - 1);

    // ------------------------------------------------------------------
    // Address decode and RAM passthrough
    // ------------------------------------------------------------------
    logic               io_sel;
    logic [MSB_ROM-1:0] io_off;
    logic               io_wr;
    logic               wr_gpio;
    logic               wr_cnt;
    logic               wr_cmp;
    logic               wr_status;
    logic               wr_uart;

    assign io_sel    = (dm.ADDR_dm_i >= IO_BASE);
    assign io_off    = dm.ADDR_dm_i - IO_BASE;
    assign io_wr     = dm.WRRAM_i & io_sel;
    assign wr_gpio   = io_wr & (io_off == c_OFF_GPIO_OUT);
    assign wr_cnt    = io_wr & (io_off == c_OFF_TIMER_CNT);
    assign wr_cmp    = io_wr & (io_off == c_OFF_TIMER_CMP);
    assign wr_status = io_wr & (io_off == c_OFF_STATUS);
    assign wr_uart   = io_wr & (io_off == c_OFF_UART_TX);

    assign WRRAM_ram_o = dm.WRRAM_i & ~io_sel;
    assign ADDR_ram_o  = dm.ADDR_dm_i;
    assign DATA_ram_o  = dm.IN_DATA_i;

    // ------------------------------------------------------------------
    // GPIO and timer register bank
    // ------------------------------------------------------------------
    logic [7:0]             gpio_out_q, gpio_out_d;
    logic [7:0]             gpio_s1_q,  gpio_s1_d;
    logic [7:0]             gpio_s2_q,  gpio_s2_d;
    logic [PW-1:0]          presc_q,    presc_d;
    logic [MSB_OPERAND-1:0] cnt_q,      cnt_d;
    logic [MSB_OPERAND-1:0] cmp_q,      cmp_d;
    logic                   match_q,    match_d;

    logic                   tick;
    logic [MSB_OPERAND-1:0] cnt_next;
    logic                   match_hit;

    always_comb begin
        gpio_out_d = wr_gpio ? dm.IN_DATA_i[7:0] : gpio_out_q;
        gpio_s1_d  = GPIO_i;
        gpio_s2_d  = gpio_s1_q;

        // A counter write also restarts the prescaler so the next tick is a
        // full PRESCALE clocks away from the newly loaded value.
        tick    = (presc_q == c_PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (wr_cnt) begin
            presc_d = '0;
        end

`ifdef TIMER_AUTORELOAD_EN
        // Hold the compare value for one tick, then restart from zero.
        cnt_next = (cnt_q == cmp_q) ? '0 : cnt_q + MSB_OPERAND'(1);
`else
        cnt_next = cnt_q + MSB_OPERAND'(1);
`endif
        match_hit = tick & ~wr_cnt & (cnt_next == cmp_q);

        cnt_d = cnt_q;
        if (wr_cnt) begin
            cnt_d = dm.IN_DATA_i;
        end else if (tick) begin
            cnt_d = cnt_next;
        end

        cmp_d   = wr_cmp ? dm.IN_DATA_i : cmp_q;
        // A fresh match outranks a simultaneous write-1-clear.
        match_d = match_hit | (match_q & ~(wr_status & dm.IN_DATA_i[0]));
    end

    always_ff @(posedge CLOCK_i or posedge RESET_i) begin
        if (RESET_i) begin
            gpio_out_q <= '0;
            gpio_s1_q  <= '0;
            gpio_s2_q  <= '0;
            presc_q    <= '0;
            cnt_q      <= '0;
            cmp_q      <= '1;
            match_q    <= 1'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            gpio_s1_q  <= gpio_s1_d;
            gpio_s2_q  <= gpio_s2_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            cmp_q      <= cmp_d;
            match_q    <= match_d;
        end
    end

    assign GPIO_o = gpio_out_q;

    // ------------------------------------------------------------------
    // UART transmitter, 8N1, LSB first
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    uart_state_t   uart_state_q;
    logic [BW-1:0] baud_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shreg_q;
    logic          tx_q;
    logic          baud_last;
    logic          uart_busy;

    assign baud_last = (baud_cnt_q == c_BAUD_LAST);
    assign uart_busy = (uart_state_q != S_IDLE);

    always_ff @(posedge CLOCK_i or posedge RESET_i) begin
        if (RESET_i) begin
            uart_state_q <= S_IDLE;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            tx_q         <= 1'b1;
        end else begin
            case (uart_state_q)
                S_IDLE: begin
                    baud_cnt_q <= '0;
                    if (wr_uart) begin
                        uart_state_q <= S_START;
                        shreg_q      <= dm.IN_DATA_i[7:0];
                        tx_q         <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        uart_state_q <= S_DATA;
                        baud_cnt_q   <= '0;
                        bit_idx_q    <= '0;
                        tx_q         <= shreg_q[0];
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            uart_state_q <= S_STOP;
                            tx_q         <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shreg_q   <= {1'b0, shreg_q[7:1]};
                            tx_q      <= shreg_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        uart_state_q <= S_IDLE;
                        baud_cnt_q   <= '0;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BW'(1);
                    end
                end
                default: begin
                    uart_state_q <= S_IDLE;
                    tx_q         <= 1'b1;
                end
            endcase
        end
    end

    assign UART_TX_o = tx_q;

    // ------------------------------------------------------------------
    // Read path: zero-latency mux, unmapped and write-only offsets read 0
    // ------------------------------------------------------------------
    logic [MSB_OPERAND-1:0] io_rdata;

    always_comb begin
        io_rdata = '0;
        case (io_off)
            c_OFF_GPIO_OUT:  io_rdata[7:0] = gpio_out_q;
            c_OFF_GPIO_IN:   io_rdata[7:0] = gpio_s2_q;
            c_OFF_TIMER_CNT: io_rdata      = cnt_q;
            c_OFF_TIMER_CMP: io_rdata      = cmp_q;
            c_OFF_STATUS:    io_rdata[1:0] = {uart_busy, match_q};
            default:         io_rdata      = '0;
        endcase
    end

    assign dm.OUT_DATA_o = io_sel ? io_rdata : DATA_ram_i;

endmodule
`default_nettype wire
